pipe_stage_reg: RTL and testbench
=================================

# pipe_stage_reg

Parametrised pipeline stage register with valid/ready flow control, a two-entry skid buffer, synchronous flush and bubble accounting. It is the generic successor to the fixed-field stage registers between IF/ID/EX/MEM/WB. Every stage boundary in the pipeline instantiates it with its own payload and control widths. Stalls propagate by back-pressure, and flushes (branch taken, exception) squash held entries by clearing their control bits.

## Interface
- DATA_W, 128: payload width (PC, operands, immediate, register indices), passed unmodified.
- CTRL_W, 8: control-signal width (RegWrite, MemRead, MemWrite, ...); forced to zero in bubbles.
- SKID_EN, 1: 1 = two-entry skid buffer with registered in_ready; 0 = single register with combinational in_ready.
- CNT_W, 8: width of the squash counter.

Ports:
- clock  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high
- in_valid  in  1  upstream entry valid
- in_ready  out  1  stage can accept this cycle
- in_data  in  DATA_W  upstream payload
- in_ctrl  in  CTRL_W  upstream control
- flush  in  1  synchronous squash of all held entries and any same-cycle input
- out_valid  out  1  downstream entry valid
- out_ready  in  1  downstream accepts
- out_data  out  DATA_W  payload to next stage
- out_ctrl  out  CTRL_W  control to next stage; 0 whenever out_valid=0
- occupancy  out  2  held entries (0..2; max 1 when SKID_EN=0)
- squash_cnt  out  CNT_W  saturating count of valid entries killed by flush
- squash_clr  in  1  synchronous clear of squash_cnt

## Operation
- Storage consists of a main register (drives out_*) and, when SKID_EN=1, a skid register. Each has a valid bit.
- An input transfer occurs when in_valid & in_ready & !flush. An output transfer occurs when out_valid & out_ready.
- SKID_EN=1:
  - in_ready = !skid_valid, derived from a flop only.
  - The main register loads when it is empty or an output transfer occurs. Its source is the skid register if skid_valid, otherwise the input (if an input transfer occurs), otherwise it becomes empty.
  - The skid register captures the input when an input transfer occurs while main is valid and no output transfer occurs.
  - Order is preserved: the skid entry always leaves before any newer input.
- SKID_EN=0:
  - in_ready = !out_valid | out_ready, combinational.
  - Main loads on an input transfer, or empties on an output transfer with no input.
- Flush has priority over all other events. In the flush cycle:
  - Both valid bits clear next edge.
  - out_ctrl/skid ctrl clear to 0. Data fields hold (don't-care).
  - The same-cycle input is discarded.
  - squash_cnt += number of valid held entries (0, 1 or 2). An input transfer dropped by flush is not counted.
- squash_cnt saturates at 2^CNT_W-1. squash_clr zeroes it; if it coincides with a flush, the counter loads that cycle's squash count.
- Bubble rule: out_valid=0 implies out_ctrl=0, at all times including after flush and reset.
- occupancy = main_valid + skid_valid.

## Timing
- Reset (asynchronous, immediate) sets:
  - out_valid=0, out_data=0, out_ctrl=0, skid cleared, occupancy=0, squash_cnt=0.
  - in_ready=1 (SKID_EN=1) or 1 via !out_valid (SKID_EN=0).
- Latency is 1 cycle: an input accepted at edge N appears on out_* after edge N when main is empty or draining.
- Throughput is 1 entry/cycle with out_ready held high.
- Back-pressure, SKID_EN=1:
  - After out_ready drops, the stage absorbs at most one more entry (into skid).
  - in_ready falls the cycle after skid fills.
  - in_ready rises the cycle after the skid entry moves to main.
- Full (occupancy=2) with out_ready=1 and in_valid=1: main←skid, and no input is taken because in_ready=0. The next cycle accepts input.
- Empty with in_valid=1 and out_ready=0: the entry goes to main. Skid is used only if the next input arrives before the drain.
- Flush with out_ready=1: the downstream handshake in the flush cycle still completes, so the entry presented that cycle is consumed, not counted as squashed, and not replayed.
- Reset mid-stall or mid-flush: all state clears immediately; squash_cnt is lost.

## Test plan
- Streaming: SKID_EN=1 with out_ready=1, push 0x1..0x8 on consecutive cycles. Outputs 0x1..0x8 appear one cycle later, back-to-back, and occupancy stays ≤1.
- Stall: push 0xA, 0xB, 0xC with out_ready=0 from cycle 1.
  - Expect occupancy=2 and in_ready=0, with 0xC held off.
  - Raise out_ready: outputs 0xA, 0xB, 0xC in order with no loss.
- Flush full: occupancy=2 with ctrl=0xFF. Assert flush with in_valid=1 (0xD).
  - Next cycle: out_valid=0, out_ctrl=0, occupancy=0, squash_cnt=2, and 0xD is absent downstream.
- Saturation: CNT_W=2, apply 5 single-entry flushes → squash_cnt=3. squash_clr → 0. squash_clr with a 1-entry flush in the same cycle → 1.
- SKID_EN=0: in_ready tracks !out_valid|out_ready combinationally. A stall holds one entry, and in_ready=0 during it.
- Async reset: assert reset mid-stall between edges. All outputs clear immediately, and in_ready=1 after release.

Source files
------------

// File: rtl/pipe_stage_reg.sv
// -----------------------------------------------------------------------------
// pipe_stage_reg
//
// Generic pipeline stage register with valid/ready flow control, an optional
// two-entry skid buffer, synchronous flush and a saturating squash counter.
// Placed at every stage boundary (IF/ID/EX/MEM/WB) with its own payload and
// control widths. A flush squashes held entries by clearing their valid and
// control bits; payload fields are left as-is.
//
// Parameters:
//   DATA_W  payload width, passed through unmodified
//   CTRL_W  control width, forced to zero in bubbles
//   SKID_EN 1 = main + skid register, in_ready from a flop
//           0 = main register only, in_ready combinational
//   CNT_W   squash counter width
//
// Ports:
//   clock       rising-edge clock
//   reset       asynchronous, active-high reset
//   in_valid    upstream entry valid
//   in_ready    stage can accept this cycle
//   in_data     upstream payload
//   in_ctrl     upstream control
//   flush       synchronous squash of held entries and same-cycle input
//   out_valid   downstream entry valid
//   out_ready   downstream accepts
//   out_data    payload to next stage
//   out_ctrl    control to next stage, zero whenever out_valid is low
//   occupancy   number of held entries (0..2)
//   squash_cnt  saturating count of valid entries killed by flush
//   squash_clr  synchronous clear of squash_cnt
// -----------------------------------------------------------------------------
module pipe_stage_reg #(
  parameter int DATA_W  = 128,
  parameter int CTRL_W  = 8,
  parameter int SKID_EN = 1,
  parameter int CNT_W   = 8
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [1:0]        occupancy,
  output logic [CNT_W-1:0]  squash_cnt,
  input  logic              squash_clr
);

  localparam logic             USE_SKID = (SKID_EN != 32'sd0);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  // Saturating add of a small increment (0..2) to the squash counter.
  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] base,
                                               input logic [1:0]       inc);
    logic [CNT_W:0] sum;
    sum = (CNT_W+1)'(base) + (CNT_W+1)'(inc);
    if (sum > (CNT_W+1)'(CNT_MAX)) begin
      return CNT_MAX;
    end else begin
      return sum[CNT_W-1:0];
    end
  endfunction

  // Storage state
  logic              main_valid_r, skid_valid_r;
  logic [DATA_W-1:0] main_data_r,  skid_data_r;
  logic [CTRL_W-1:0] main_ctrl_r,  skid_ctrl_r;
  logic [CNT_W-1:0]  squash_cnt_r;

  // Next-state values
  logic              main_valid_s, skid_valid_s;
  logic [DATA_W-1:0] main_data_s,  skid_data_s;
  logic [CTRL_W-1:0] main_ctrl_s,  skid_ctrl_s;
  logic [CNT_W-1:0]  squash_cnt_s;

  // Handshake terms
  logic       in_ready_s;
  logic       in_xfer_s;
  logic       out_xfer_s;
  logic       main_load_s;
  logic [1:0] squash_inc_s;

  // With the skid buffer, in_ready depends only on the skid valid flop, which
  // breaks the out_ready -> in_ready timing path between stages.
  assign in_ready_s   = USE_SKID ? ~skid_valid_r : (~main_valid_r | out_ready);
  assign in_xfer_s    = in_valid & in_ready_s & ~flush;
  assign out_xfer_s   = main_valid_r & out_ready;
  assign main_load_s  = ~main_valid_r | out_xfer_s;
  // An entry leaving downstream in the flush cycle completes its handshake,
  // so only entries that stay behind are counted as squashed.
  assign squash_inc_s = {1'b0, main_valid_r & ~out_ready} + {1'b0, skid_valid_r};

  // Next-state logic for the main and skid registers.
  always_comb begin
    main_valid_s = main_valid_r;
    main_data_s  = main_data_r;
    main_ctrl_s  = main_ctrl_r;
    skid_valid_s = skid_valid_r;
    skid_data_s  = skid_data_r;
    skid_ctrl_s  = skid_ctrl_r;
    if (flush) begin
      // Squash: drop valid and control, leave payload untouched.
      main_valid_s = 1'b0;
      main_ctrl_s  = '0;
      skid_valid_s = 1'b0;
      skid_ctrl_s  = '0;
    end else if (USE_SKID) begin
      if (main_load_s) begin
        if (skid_valid_r) begin
          // Older skid entry always goes first; in_ready is low so no input.
          main_valid_s = 1'b1;
          main_data_s  = skid_data_r;
          main_ctrl_s  = skid_ctrl_r;
          skid_valid_s = 1'b0;
          skid_ctrl_s  = '0;
        end else if (in_xfer_s) begin
          main_valid_s = 1'b1;
          main_data_s  = in_data;
          main_ctrl_s  = in_ctrl;
        end else begin
          main_valid_s = 1'b0;
          main_ctrl_s  = '0;
        end
      end else if (in_xfer_s) begin
        // Main is stalled and skid is known empty (in_ready was high).
        skid_valid_s = 1'b1;
        skid_data_s  = in_data;
        skid_ctrl_s  = in_ctrl;
      end else begin
        skid_valid_s = skid_valid_r;
      end
    end else begin
      if (in_xfer_s) begin
        main_valid_s = 1'b1;
        main_data_s  = in_data;
        main_ctrl_s  = in_ctrl;
      end else if (out_xfer_s) begin
        main_valid_s = 1'b0;
        main_ctrl_s  = '0;
      end else begin
        main_valid_s = main_valid_r;
      end
    end
  end

  // Next-state logic for the squash counter; a clear coinciding with a flush
  // restarts the count from this cycle's squashed entries.
  always_comb begin
    squash_cnt_s = squash_cnt_r;
    if (squash_clr) begin
      if (flush) begin
        squash_cnt_s = sat_add('0, squash_inc_s);
      end else begin
        squash_cnt_s = '0;
      end
    end else if (flush) begin
      squash_cnt_s = sat_add(squash_cnt_r, squash_inc_s);
    end else begin
      squash_cnt_s = squash_cnt_r;
    end
  end

  // State registers with asynchronous reset.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      main_valid_r <= 1'b0;
      main_data_r  <= '0;
      main_ctrl_r  <= '0;
      skid_valid_r <= 1'b0;
      skid_data_r  <= '0;
      skid_ctrl_r  <= '0;
      squash_cnt_r <= '0;
    end else begin
      main_valid_r <= main_valid_s;
      main_data_r  <= main_data_s;
      main_ctrl_r  <= main_ctrl_s;
      skid_valid_r <= skid_valid_s;
      skid_data_r  <= skid_data_s;
      skid_ctrl_r  <= skid_ctrl_s;
      squash_cnt_r <= squash_cnt_s;
    end
  end

  assign in_ready   = in_ready_s;
  assign out_valid  = main_valid_r;
  assign out_data   = main_data_r;
  assign out_ctrl   = main_ctrl_r;
  assign occupancy  = {1'b0, main_valid_r} + {1'b0, skid_valid_r};
  assign squash_cnt = squash_cnt_r;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// -----------------------------------------------------------------------------
// tb_pipe_stage_reg
//
// Directed bench for pipe_stage_reg. Three instances share one set of inputs:
//   dut_a  default parameters (skid buffer, 8-bit squash counter)
//   dut_b  CNT_W=2 for counter saturation
//   dut_c  SKID_EN=0 for the combinational in_ready variant
// Inputs change #1 after the rising edge; outputs are sampled there too.
// -----------------------------------------------------------------------------
module tb_pipe_stage_reg;

  logic         clock = 1'b0;
  logic         reset = 1'b0;
  logic         in_valid = 1'b0;
  logic [127:0] in_data = '0;
  logic [7:0]   in_ctrl = '0;
  logic         flush = 1'b0;
  logic         out_ready = 1'b0;
  logic         squash_clr = 1'b0;

  logic         a_in_ready, b_in_ready, c_in_ready;
  logic         a_out_valid, b_out_valid, c_out_valid;
  logic [127:0] a_out_data, b_out_data, c_out_data;
  logic [7:0]   a_out_ctrl, b_out_ctrl, c_out_ctrl;
  logic [1:0]   a_occ, b_occ, c_occ;
  logic [7:0]   a_sq, c_sq;
  logic [1:0]   b_sq;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clock = ~clock;

  pipe_stage_reg dut_a (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(a_in_ready),
    .in_data(in_data), .in_ctrl(in_ctrl), .flush(flush), .out_valid(a_out_valid),
    .out_ready(out_ready), .out_data(a_out_data), .out_ctrl(a_out_ctrl),
    .occupancy(a_occ), .squash_cnt(a_sq), .squash_clr(squash_clr)
  );

  pipe_stage_reg #(.CNT_W(2)) dut_b (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(b_in_ready),
    .in_data(in_data), .in_ctrl(in_ctrl), .flush(flush), .out_valid(b_out_valid),
    .out_ready(out_ready), .out_data(b_out_data), .out_ctrl(b_out_ctrl),
    .occupancy(b_occ), .squash_cnt(b_sq), .squash_clr(squash_clr)
  );

  pipe_stage_reg #(.SKID_EN(0)) dut_c (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(c_in_ready),
    .in_data(in_data), .in_ctrl(in_ctrl), .flush(flush), .out_valid(c_out_valid),
    .out_ready(out_ready), .out_data(c_out_data), .out_ctrl(c_out_ctrl),
    .occupancy(c_occ), .squash_cnt(c_sq), .squash_clr(squash_clr)
  );

  task automatic check_eq(input string tag, input logic [127:0] got,
                          input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Assert reset between edges, check immediate clear, release on negedge.
  task automatic do_reset();
    reset = 1'b1;
    #1;
    check_eq("rst a out_valid", 128'(a_out_valid), 128'h0);
    check_eq("rst a out_data",  128'(a_out_data),  128'h0);
    check_eq("rst a out_ctrl",  128'(a_out_ctrl),  128'h0);
    check_eq("rst a occupancy", 128'(a_occ),       128'h0);
    check_eq("rst a squash",    128'(a_sq),        128'h0);
    check_eq("rst a in_ready",  128'(a_in_ready),  128'h1);
    check_eq("rst b squash",    128'(b_sq),        128'h0);
    check_eq("rst c in_ready",  128'(c_in_ready),  128'h1);
    check_eq("rst c out_valid", 128'(c_out_valid), 128'h0);
    @(negedge clock);
    reset = 1'b0;
    tick();
  endtask

  initial begin
    #2;
    do_reset();

    // Streaming with out_ready high: one-cycle latency, back-to-back.
    out_ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      in_valid = 1'b1;
      in_data  = 128'(i);
      in_ctrl  = 8'h10 | 8'(i);
      tick();
      check_eq($sformatf("stream a valid %0d", i), 128'(a_out_valid), 128'h1);
      check_eq($sformatf("stream a data %0d", i),  a_out_data,        128'(i));
      check_eq($sformatf("stream a ctrl %0d", i),  128'(a_out_ctrl),  128'(8'h10 | 8'(i)));
      check_eq($sformatf("stream a occ %0d", i),   128'(a_occ),       128'h1);
      check_eq($sformatf("stream c data %0d", i),  c_out_data,        128'(i));
    end
    in_valid = 1'b0;
    tick();
    check_eq("stream drain valid", 128'(a_out_valid), 128'h0);
    check_eq("stream drain ctrl",  128'(a_out_ctrl),  128'h0);
    check_eq("stream drain occ",   128'(a_occ),       128'h0);

    // Stall: A to main, B to skid, C held off.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_ctrl   = 8'h01;
    in_data   = 128'hA;
    tick();
    check_eq("stall a data A",     a_out_data,        128'hA);
    check_eq("stall a occ 1",      128'(a_occ),       128'h1);
    check_eq("stall a in_ready 1", 128'(a_in_ready),  128'h1);
    check_eq("noskid c occ 1",     128'(c_occ),       128'h1);
    check_eq("noskid c in_ready",  128'(c_in_ready),  128'h0);
    in_data = 128'hB;
    tick();
    check_eq("stall a occ 2",      128'(a_occ),       128'h2);
    check_eq("stall a in_ready 0", 128'(a_in_ready),  128'h0);
    check_eq("stall a data hold",  a_out_data,        128'hA);
    in_data = 128'hC;
    tick();
    check_eq("stall a occ C off",  128'(a_occ),       128'h2);
    check_eq("stall a rdy C off",  128'(a_in_ready),  128'h0);
    check_eq("stall a data A2",    a_out_data,        128'hA);
    check_eq("noskid c hold A",    c_out_data,        128'hA);
    out_ready = 1'b1;
    #1;
    check_eq("noskid c comb rdy",  128'(c_in_ready),  128'h1);
    check_eq("skid a flop rdy",    128'(a_in_ready),  128'h0);
    tick();
    check_eq("drain a data B",     a_out_data,        128'hB);
    check_eq("drain a occ 1",      128'(a_occ),       128'h1);
    check_eq("drain a rdy back",   128'(a_in_ready),  128'h1);
    check_eq("noskid c data C",    c_out_data,        128'hC);
    tick();
    check_eq("drain a data C",     a_out_data,        128'hC);
    check_eq("drain a valid C",    128'(a_out_valid), 128'h1);
    in_valid = 1'b0;
    tick();
    check_eq("drain a empty",      128'(a_out_valid), 128'h0);
    check_eq("drain a occ 0",      128'(a_occ),       128'h0);

    // Flush of a full stage with a same-cycle input.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_ctrl   = 8'hFF;
    in_data   = 128'h21;
    tick();
    in_data = 128'h22;
    tick();
    check_eq("flush pre occ",      128'(a_occ),       128'h2);
    check_eq("flush pre ctrl",     128'(a_out_ctrl),  128'hFF);
    flush   = 1'b1;
    in_data = 128'hD;
    tick();
    flush    = 1'b0;
    in_valid = 1'b0;
    check_eq("flush a valid",      128'(a_out_valid), 128'h0);
    check_eq("flush a ctrl",       128'(a_out_ctrl),  128'h0);
    check_eq("flush a occ",        128'(a_occ),       128'h0);
    check_eq("flush a squash",     128'(a_sq),        128'h2);
    check_eq("flush b squash",     128'(b_sq),        128'h2);
    out_ready = 1'b1;
    tick();
    check_eq("flush D absent",     128'(a_out_valid), 128'h0);

    // Flush while downstream accepts: the presented entry is not counted.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_ctrl   = 8'h05;
    in_data   = 128'h31;
    tick();
    in_valid  = 1'b0;
    out_ready = 1'b1;
    flush     = 1'b1;
    tick();
    flush = 1'b0;
    check_eq("flush+ready squash", 128'(a_sq),        128'h2);
    check_eq("flush+ready valid",  128'(a_out_valid), 128'h0);

    // Async reset in the middle of a stall.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 128'h41;
    tick();
    in_data = 128'h42;
    tick();
    in_valid = 1'b0;
    check_eq("midstall occ",       128'(a_occ),       128'h2);
    #2;
    do_reset();
    check_eq("post rst in_ready",  128'(a_in_ready),  128'h1);

    // Saturation of the 2-bit counter with single-entry flushes.
    out_ready = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      in_valid = 1'b1;
      in_data  = 128'(k);
      tick();
      in_valid = 1'b0;
      flush    = 1'b1;
      tick();
      flush = 1'b0;
      check_eq($sformatf("sat b squash %0d", k), 128'(b_sq), 128'((k < 3) ? k : 3));
    end
    check_eq("sat a squash 5",     128'(a_sq),        128'h5);
    squash_clr = 1'b1;
    tick();
    squash_clr = 1'b0;
    check_eq("clr b squash",       128'(b_sq),        128'h0);
    check_eq("clr a squash",       128'(a_sq),        128'h0);
    in_valid = 1'b1;
    in_data  = 128'h51;
    tick();
    in_valid   = 1'b0;
    flush      = 1'b1;
    squash_clr = 1'b1;
    tick();
    flush      = 1'b0;
    squash_clr = 1'b0;
    check_eq("clr+flush b squash", 128'(b_sq),        128'h1);
    check_eq("clr+flush a squash", 128'(a_sq),        128'h1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
